// File: rtl/dmg_mbc_pkg.sv
// Shared types and address map for the DMG MBC1 cartridge mapper.
package dmg_mbc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mbc_state_t;

    typedef enum logic [1:0] {
        RG_ROM  = 2'd0,
        RG_RAM  = 2'd1,
        RG_NONE = 2'd2
    } region_t;

    localparam logic [15:0] ROM0_BASE = 16'h0000;
    localparam logic [15:0] ROMX_BASE = 16'h4000;
    localparam logic [15:0] RAM_BASE  = 16'hA000;
    localparam logic [3:0]  RAM_EN_KEY = 4'hA;

    function automatic region_t decode_region(input logic [15:0] addr);
        region_t rg;
        if (addr[15:14] == ROM0_BASE[15:14] || addr[15:14] == ROMX_BASE[15:14]) begin
            rg = RG_ROM;
        end else if (addr[15:13] == RAM_BASE[15:13]) begin
            rg = RG_RAM;
        end else begin
            rg = RG_NONE;
        end
        return rg;
    endfunction

endpackage

// File: rtl/mbc1_cart_ram.sv
// Single-port synchronous cart RAM with one-cycle registered read.
module mbc1_cart_ram #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mbc1_mapper.sv
// MBC1 bank controller: register decode, ROM bank mapping and a 3-edge read path.
// Optional battery-less cart RAM in 0xA000-0xBFFF is built when CART_RAM_EN is defined.
module mbc1_mapper
    import dmg_mbc_pkg::*;
#(
    parameter int unsigned ROM_ADDR_W = 15,
    parameter int unsigned RAM_ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  cpu_busy,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_data
);

    logic                  wr_q, rd_q, wr_edge, rd_edge;
    logic [4:0]            bank_lo;
    logic [1:0]            bank_hi;
    logic                  mode, ram_en;
    mbc_state_t            state;
    region_t               region_q;
    logic [6:0]            bank;
    logic [ROM_ADDR_W-1:0] mapped;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [7:0]            ram_rdata;

    assign wr_edge = cpu_wr & ~wr_q;
    assign rd_edge = cpu_rd & ~rd_q;

    always_comb begin
        bank = 7'd0;
        if (cpu_addr < ROMX_BASE) begin
            bank = mode ? {bank_hi, 5'b0} : 7'd0;
        end else begin
            bank = {bank_hi, bank_lo};
        end
    end

    // Bank bits above the ROM width are dropped so small ROMs mirror.
    assign mapped   = ROM_ADDR_W'({bank, cpu_addr[13:0]});
    assign ram_addr = RAM_ADDR_W'(mode ? {bank_hi, cpu_addr[12:0]} : {2'b00, cpu_addr[12:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            bank_lo <= 5'd1;
            bank_hi <= 2'd0;
            mode    <= 1'b0;
            ram_en  <= 1'b0;
        end else begin
            wr_q <= cpu_wr;
            rd_q <= cpu_rd;
            if (wr_edge) begin
                case (cpu_addr[15:13])
                    3'b000: ram_en  <= (cpu_wdata[3:0] == RAM_EN_KEY);
                    3'b001: bank_lo <= (cpu_wdata[4:0] == 5'd0) ? 5'd1 : cpu_wdata[4:0];
                    3'b010: bank_hi <= cpu_wdata[1:0];
                    3'b011: mode    <= cpu_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            region_q   <= RG_NONE;
            rom_addr   <= '0;
            cpu_rdata  <= 8'hFF;
            cpu_rvalid <= 1'b0;
            cpu_busy   <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_edge) begin
                        rom_addr <= mapped;
                        region_q <= decode_region(cpu_addr);
                        cpu_busy <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    case (region_q)
                        RG_ROM:  cpu_rdata <= rom_data;
                        RG_RAM:  cpu_rdata <= ram_rdata;
                        default: cpu_rdata <= 8'hFF;
                    endcase
                    cpu_rvalid <= 1'b1;
                    cpu_busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CART_RAM_EN
    logic [RAM_ADDR_W-1:0] ram_rd_addr_q, ram_port_addr;
    logic                  ram_we;
    logic [7:0]            ram_dout;

    assign ram_we        = wr_edge & ram_en & (decode_region(cpu_addr) == RG_RAM);
    // Writes borrow the single port; the read address is held from E0 onward.
    assign ram_port_addr = ram_we ? ram_addr : ram_rd_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_addr_q <= '0;
        end else if (state == IDLE && rd_edge) begin
            ram_rd_addr_q <= ram_addr;
        end
    end

    mbc1_cart_ram #(
        .ADDR_W (RAM_ADDR_W)
    ) u_cart_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_port_addr),
        .wdata (cpu_wdata),
        .rdata (ram_dout)
    );

    assign ram_rdata = ram_en ? ram_dout : 8'hFF;
`else
    logic unused_sig;
    assign unused_sig = ^{ram_en, cpu_wdata[7:5], ram_addr};
    assign ram_rdata  = 8'hFF;
`endif

endmodule

// File: tb/tb_mbc1_mapper.sv
// Self-checking bench for mbc1_mapper against a behavioural MBC1 model.
module tb_mbc1_mapper;

    localparam int ROM_W = 15;
    localparam int RAM_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      cpu_addr;
    logic [7:0]       cpu_wdata;
    logic             cpu_wr, cpu_rd;
    logic [7:0]       cpu_rdata;
    logic             cpu_rvalid, cpu_busy;
    logic [ROM_W-1:0] rom_addr;
    logic [7:0]       rom_data;

    logic [7:0] rom [1 << ROM_W];
    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural MBC1 register state
    int m_lo, m_hi, m_mode, m_ram_en;
    int ram_m [int];

    mbc1_mapper #(
        .ROM_ADDR_W (ROM_W),
        .RAM_ADDR_W (RAM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_busy   (cpu_busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lo = 1; m_hi = 0; m_mode = 0; m_ram_en = 0;
    endtask

    function automatic int exp_rom_addr(input int a);
        int bnk;
        if (a < 'h4000) bnk = m_mode ? m_hi * 32 : 0;
        else            bnk = m_hi * 32 + m_lo;
        return (bnk * 16384 + (a % 16384)) % (1 << ROM_W);
    endfunction

    function automatic int ram_index(input int a);
        int base;
        base = m_mode ? m_hi * 8192 : 0;
        return (base + (a % 8192)) % (1 << RAM_W);
    endfunction

    // Returns -1 where the expected byte is not known (unwritten RAM).
    function automatic int exp_data(input int a);
        if (a < 'h8000) return int'(rom[exp_rom_addr(a)]);
        if (a >= 'hA000 && a < 'hC000) begin
`ifdef CART_RAM_EN
            if (m_ram_en == 0) return 'hFF;
            if (ram_m.exists(ram_index(a))) return ram_m[ram_index(a)];
            return -1;
`else
            return 'hFF;
`endif
        end
        return 'hFF;
    endfunction

    task automatic model_write(input int a, input int d);
        if (a < 'h2000)      m_ram_en = ((d % 16) == 10) ? 1 : 0;
        else if (a < 'h4000) m_lo = ((d % 32) == 0) ? 1 : d % 32;
        else if (a < 'h6000) m_hi = d % 4;
        else if (a < 'h8000) m_mode = d % 2;
`ifdef CART_RAM_EN
        else if (a >= 'hA000 && a < 'hC000 && m_ram_en != 0) ram_m[ram_index(a)] = d;
`endif
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        model_write(int'(a), int'(d));
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        int e_addr, e_data, lat;
        e_addr = exp_rom_addr(int'(a));
        e_data = exp_data(int'(a));
        @(negedge clk);
        cpu_addr = a; cpu_rd = 1'b1;
        @(posedge clk); #1;
        if (a < 16'h8000) check({tag, ":rom_addr"}, 32'(rom_addr), e_addr);
        check({tag, ":busy_set"}, 32'(cpu_busy), 1);
        @(negedge clk);
        cpu_rd = 1'b0;
        lat = 0;
        while (!cpu_rvalid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, lat, 2);
        if (e_data >= 0) check({tag, ":rdata"}, 32'(cpu_rdata), e_data);
        check({tag, ":busy_clr"}, 32'(cpu_busy), 0);
        @(posedge clk); #1;
        check({tag, ":rvalid_pulse"}, 32'(cpu_rvalid), 0);
    endtask

    initial begin
        int e_data, n_valid, got;
        logic [15:0] ra;
        logic [7:0]  rd;

        for (int i = 0; i < (1 << ROM_W); i++) rom[i] = 8'($urandom);
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        check("t1_rom_addr", 32'(rom_addr), 0);
        check("t1_rvalid", 32'(cpu_rvalid), 0);
        check("t1_busy", 32'(cpu_busy), 0);
        check("t1_rdata", 32'(cpu_rdata), 'hFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_read(16'h4000, "t1_bank_lo_is_1");

        // T2 ROM0 read
        do_read(16'h0123, "t2_rom0");
        check("t2_rom_addr_abs", 32'(rom_addr), 'h0123);

        // T3 bank switch and wrap
        do_write(16'h2000, 8'h00);
        do_read(16'h4005, "t3_bank1");
        check("t3_rom_addr_abs1", 32'(rom_addr), 'h4005);
        do_write(16'h2000, 8'h02);
        do_read(16'h4005, "t3_bank2_wrap");
        check("t3_rom_addr_abs2", 32'(rom_addr), 'h0005);

        // T4 mode 1 with high bank on ROM0
        do_write(16'h4000, 8'h01);
        do_write(16'h6000, 8'h01);
        do_read(16'h0010, "t4_mode_hi");
        check("t4_rom_addr_abs", 32'(rom_addr), 'h0010);

        // T5 simultaneous write+read, then a dropped read edge while busy
        e_data = exp_data('h2000);
        @(negedge clk);
        cpu_addr = 16'h2000; cpu_wdata = 8'h03; cpu_wr = 1'b1; cpu_rd = 1'b1;
        @(posedge clk); #1;
        check("t5_busy", 32'(cpu_busy), 1);
        model_write('h2000, 'h03);
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        cpu_rd = 1'b1;
        n_valid = 0; got = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cpu_rvalid) begin
                n_valid++;
                got = int'(cpu_rdata);
            end
        end
        check("t5_single_rvalid", n_valid, 1);
        check("t5_rdata", got, e_data);
        check("t5_idle_after", 32'(cpu_busy), 0);
        check("t5_rom_addr_held", 32'(rom_addr), 'h2000);
        @(negedge clk);
        cpu_rd = 1'b0;
        do_read(16'h4000, "t5_bank_lo_3");

        // T6 cart RAM window
`ifdef CART_RAM_EN
        do_write(16'h0000, 8'h0A);
        do_write(16'hA010, 8'h5A);
        do_read(16'hA010, "t6_ram_on");
        check("t6_ram_abs", 32'(cpu_rdata), 'h5A);
        do_write(16'h0000, 8'h00);
        do_read(16'hA010, "t6_ram_off");
        check("t6_ram_off_abs", 32'(cpu_rdata), 'hFF);
`else
        do_write(16'hA010, 8'h5A);
        do_read(16'hA010, "t6_no_ram");
        check("t6_no_ram_abs", 32'(cpu_rdata), 'hFF);
`endif

        // T6 reset aborts a read in flight
        @(negedge clk);
        cpu_addr = 16'h0100; cpu_rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_rd = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("t6_abort_rvalid", 32'(cpu_rvalid), 0);
        check("t6_abort_busy", 32'(cpu_busy), 0);
        check("t6_abort_rdata", 32'(cpu_rdata), 'hFF);
        check("t6_abort_rom_addr", 32'(rom_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cpu_rvalid) n_valid++;
        end
        check("t6_abort_no_late_rvalid", n_valid, 0);

        // Randomized mix of register writes and reads
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ra = 16'($urandom_range(0, 'hFFFF));
                    do_read(ra, "rnd_any");
                end
                1: begin
                    ra = 16'($urandom_range(0, 'h7FFF));
                    rd = 8'($urandom);
                    do_write(ra, rd);
                end
                2: begin
                    ra = 16'($urandom_range(0, 'h7FFF));
                    do_read(ra, "rnd_rom");
                end
                default: begin
                    ra = 16'($urandom_range('hA000, 'hA00F));
                    rd = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) do_write(16'h0000, 8'h0A);
                    do_write(ra, rd);
                    do_read(ra, "rnd_ram");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
